regfile_pw: RTL and testbench



---
 rtl/regfile_pw_pkg.sv | 12 +
 rtl/rf_clear_seq.sv | 62 ++++++
 rtl/regfile_pw.sv | 113 +++++++++++
 tb/tb_regfile_pw.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pw_pkg.sv
// regfile_pkg: shared types and default sizing for the regfile_pw register file.
//   rf_state_t : clear-sequencer state (sweeping vs. ready for writes)
//   RF_WIDTH / RF_DEPTH / RF_INIT : default data width, entry count, clear value
package regfile_pkg;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

  localparam int RF_WIDTH = 4;
  localparam int RF_DEPTH = 8;
  localparam int RF_INIT  = 1;

endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: CLEAR/READY sequencer with sweep pointer for regfile_pw.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (starts a sweep)
//   rf_clr : starts/restarts a clear sweep
//   state  : current sequencer state
//   ptr    : entry being initialised while in RF_CLEAR
//   busy   : registered copy of (state == RF_CLEAR)
module rf_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rf_clr,
  output rf_state_t     state,
  output logic [AW-1:0] ptr,
  output logic          busy
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (rf_clr) begin
      // A clear request always (re)starts the sweep from entry 0.
      state_d = RF_CLEAR;
      ptr_d   = '0;
    end else if (state_q == RF_CLEAR) begin
      if (ptr_q == LAST) begin
        state_d = RF_READY;
        ptr_d   = '0;
      end else begin
        ptr_d   = ptr_q + 1'b1;
      end
    end
    busy_d = (state_d == RF_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign state = state_q;
  assign ptr   = ptr_q;
  assign busy  = busy_q;

endmodule

// File: rtl/regfile_pw.sv
// regfile_pw: parametrised 2-read/1-write register file with registered reads,
// optional write-to-read bypass and a multi-cycle clear sweep.
//   clk, rst    : clock and synchronous active-high reset
//   rf_clr      : start a clear sweep (writes INIT_VAL to every entry)
//   en/wra/wrd  : write enable, address, data
//   rda1/rda2   : read addresses; rdd1/rdd2 : registered read data (1-cycle latency)
//   busy        : clear sweep in progress
//   wr_drop     : pulse, the previous cycle's write was discarded
module regfile_pw
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int INIT_VAL = RF_INIT,
  parameter bit BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rf_clr,
  input  logic             en,
  input  logic [AW-1:0]    wra,
  input  logic [WIDTH-1:0] wrd,
  input  logic [AW-1:0]    rda1,
  input  logic [AW-1:0]    rda2,
  output logic [WIDTH-1:0] rdd1,
  output logic [WIDTH-1:0] rdd2,
  output logic             busy,
  output logic             wr_drop
);

  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT_VAL);

  // DEPTH need not be a power of two, so addresses can exceed the array.
  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  rf_state_t     state;
  logic [AW-1:0] ptr;

  rf_clear_seq #(.DEPTH(DEPTH), .AW(AW)) u_seq (
    .clk    (clk),
    .rst    (rst),
    .rf_clr (rf_clr),
    .state  (state),
    .ptr    (ptr),
    .busy   (busy)
  );

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic             wr_acc;

  logic [WIDTH-1:0] rdd1_q, rdd1_d;
  logic [WIDTH-1:0] rdd2_q, rdd2_d;
  logic             wr_drop_q, wr_drop_d;

  // A clear request wins over the user write in the same cycle.
  assign wr_acc = (state == RF_READY) && !rf_clr && en && in_range(wra);

  // Single write port: the sweep and the user write share it, so the array
  // stays mappable to distributed RAM.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wra;
    mem_wd = wrd;
    if (state == RF_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = ptr;
      mem_wd = INIT_W;
    end else if (wr_acc) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  // The clear looks instantaneous to readers even while the sweep is running.
  function automatic logic [WIDTH-1:0] rd_fn(input logic [AW-1:0] a);
    if (state == RF_CLEAR || rf_clr) return INIT_W;
    else if (!in_range(a))           return '0;
    else if (BYPASS && wr_acc && wra == a) return wrd;
    else                             return mem_q[a];
  endfunction

  always_comb begin
    rdd1_d    = rd_fn(rda1);
    rdd2_d    = rd_fn(rda2);
    wr_drop_d = en && (state == RF_CLEAR || rf_clr || !in_range(wra));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdd1_q    <= '0;
      rdd2_q    <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      rdd1_q    <= rdd1_d;
      rdd2_q    <= rdd2_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  assign rdd1    = rdd1_q;
  assign rdd2    = rdd2_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_pw.sv
// tb_regfile_pw: directed bench for regfile_pw. Three instances share one set of
// inputs: defaults (BYPASS=1), BYPASS=0, and a non-power-of-2 DEPTH=6.
module tb_regfile_pw;

  logic       clk = 1'b0;
  logic       rst, rf_clr, en;
  logic [2:0] wra, rda1, rda2;
  logic [3:0] wrd;

  logic [3:0] b1_rdd1, b1_rdd2, b0_rdd1, b0_rdd2, d6_rdd1, d6_rdd2;
  logic       b1_busy, b0_busy, d6_busy, b1_drop, b0_drop, d6_drop;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;

  always #5 clk = ~clk;

  regfile_pw u_b1 (
    .clk(clk), .rst(rst), .rf_clr(rf_clr), .en(en), .wra(wra), .wrd(wrd),
    .rda1(rda1), .rda2(rda2), .rdd1(b1_rdd1), .rdd2(b1_rdd2),
    .busy(b1_busy), .wr_drop(b1_drop)
  );

  regfile_pw #(.BYPASS(1'b0)) u_b0 (
    .clk(clk), .rst(rst), .rf_clr(rf_clr), .en(en), .wra(wra), .wrd(wrd),
    .rda1(rda1), .rda2(rda2), .rdd1(b0_rdd1), .rdd2(b0_rdd2),
    .busy(b0_busy), .wr_drop(b0_drop)
  );

  regfile_pw #(.DEPTH(6)) u_d6 (
    .clk(clk), .rst(rst), .rf_clr(rf_clr), .en(en), .wra(wra), .wrd(wrd),
    .rda1(rda1), .rda2(rda2), .rdd1(d6_rdd1), .rdd2(d6_rdd2),
    .busy(d6_busy), .wr_drop(d6_drop)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs set afterwards apply at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rf_clr = 1'b0; en = 1'b0;
    wra = '0; wrd = '0; rda1 = '0; rda2 = '0;
    tick();
    rst = 1'b0;
    chk("rst_busy", b1_busy, 1);
    chk("rst_rdd1", b1_rdd1, 0);
    chk("rst_rdd2", b1_rdd2, 0);
    chk("rst_drop", b1_drop, 0);

    // Reset sweep: busy for exactly DEPTH cycles, reads show INIT_VAL meanwhile.
    cnt = 1;
    tick();
    chk("sweep_rdd1", b1_rdd1, 1);
    chk("sweep_rdd2", b1_rdd2, 1);
    if (b1_busy) cnt++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b1_busy) cnt++;
      else break;
    end
    chk("rst_busy_len", cnt, 8);
    chk("d6_idle", d6_busy, 0);

    for (int a = 0; a < 8; a++) begin
      rda1 = 3'(a); rda2 = 3'(7 - a);
      tick();
      chk("init_rd1", b1_rdd1, 1);
      chk("init_rd2", b1_rdd2, 1);
    end

    // Write then read back.
    en = 1'b1; wra = 3'd3; wrd = 4'hA; rda1 = 3'd0; rda2 = 3'd0;
    tick();
    en = 1'b0; rda1 = 3'd3; rda2 = 3'd2;
    chk("wr_nodrop", b1_drop, 0);
    tick();
    chk("wr_rd1_b1", b1_rdd1, 4'hA);
    chk("wr_rd2_b1", b1_rdd2, 4'h1);
    chk("wr_rd1_b0", b0_rdd1, 4'hA);

    // Bypass: mem[5]=2, then write C while reading 5 on both ports.
    en = 1'b1; wra = 3'd5; wrd = 4'h2;
    tick();
    wrd = 4'hC; rda1 = 3'd5; rda2 = 3'd5;
    tick();
    en = 1'b0;
    chk("byp_rd1_b1", b1_rdd1, 4'hC);
    chk("byp_rd2_b1", b1_rdd2, 4'hC);
    chk("byp_rd1_b0", b0_rdd1, 4'h2);
    chk("byp_rd2_b0", b0_rdd2, 4'h2);
    tick();
    chk("byp_late_b0", b0_rdd1, 4'hC);
    chk("byp_late_b1", b1_rdd2, 4'hC);

    // Clear priority: mem[1]=7, then rf_clr together with a write of F.
    en = 1'b1; wra = 3'd1; wrd = 4'h7;
    tick();
    rf_clr = 1'b1; wrd = 4'hF;
    tick();
    rf_clr = 1'b0; wra = 3'd2; wrd = 4'h9;
    chk("clr_drop", b1_drop, 1);
    chk("clr_busy", b1_busy, 1);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("busy_drop", b1_drop, 1);
      if (b1_busy) cnt++;
      else break;
    end
    en = 1'b0;
    chk("clr_busy_len", cnt, 8);
    rda1 = 3'd1; rda2 = 3'd2;
    tick();
    chk("clr_rd1", b1_rdd1, 1);
    chk("clr_rd2", b1_rdd2, 1);
    chk("clr_nodrop", b1_drop, 0);

    // Restart: rf_clr again during the 4th busy cycle.
    rf_clr = 1'b1;
    tick();
    rf_clr = 1'b0;
    cnt = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (b1_busy) cnt++;
    end
    rf_clr = 1'b1;
    tick();
    rf_clr = 1'b0;
    if (b1_busy) cnt++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b1_busy) cnt++;
      else break;
    end
    chk("restart_len", cnt, 12);

    // Non-power-of-2 depth: address 7 is out of range for DEPTH=6.
    en = 1'b1; wra = 3'd7; wrd = 4'hE;
    tick();
    en = 1'b0;
    chk("d6_drop", d6_drop, 1);
    chk("b1_nodrop7", b1_drop, 0);
    for (int a = 0; a < 6; a++) begin
      rda1 = 3'(a);
      tick();
      chk("d6_keep", d6_rdd1, 1);
    end
    rda1 = 3'd6; rda2 = 3'd7;
    tick();
    chk("d6_oor_rd1", d6_rdd1, 0);
    chk("d6_oor_rd2", d6_rdd2, 0);
    chk("b1_rd7", b1_rdd2, 4'hE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
